motor_cntrl: RTL and testbench

MOTOR_CNTRL -- requirements
Module: motor_cntrl

---
 rtl/motor_cntrl_if.sv | 28 ++
 rtl/motor_cntrl.sv | 82 ++++++++
 tb/tb_motor_cntrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/motor_cntrl_if.sv
// Command/drive bundle for the dual-channel motor PWM controller.
// The master supplies signed motor commands; the slave returns the H-bridge drives.
interface motor_cntrl_if;
    logic [10:0] lft;
    logic [10:0] rht;
    logic        fwd_lft;
    logic        rev_lft;
    logic        fwd_rht;
    logic        rev_rht;

    modport master (
        output lft,
        output rht,
        input  fwd_lft,
        input  rev_lft,
        input  fwd_rht,
        input  rev_rht
    );

    modport slave (
        input  lft,
        input  rht,
        output fwd_lft,
        output rev_lft,
        output fwd_rht,
        output rev_rht
    );
endinterface

// File: rtl/motor_cntrl.sv
// Two-channel sign/magnitude PWM motor driver sharing one 1024-clk free-running counter.
// A zero command brakes, and every drive output is registered for glitch-free switching.
module motor_cntrl (
    input  logic          clk,
    input  logic          rst_n,
    motor_cntrl_if.slave  mc
);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;
    logic [9:0] mag_lft;
    logic [9:0] mag_rht;
    logic       pwm_lft;
    logic       pwm_rht;
    logic       fwd_lft_q, rev_lft_q, fwd_rht_q, rev_rht_q;
    logic       fwd_lft_d, rev_lft_d, fwd_rht_d, rev_rht_d;

    // The most negative command (-1024) has no 10-bit magnitude, so it clamps to 1023.
    function automatic logic [9:0] mag_of(input logic [10:0] cmd);
        logic [10:0] neg;
        neg = -cmd;
        if (!cmd[10]) begin
            return cmd[9:0];
        end
        if (neg[10]) begin
            return 10'h3ff;
        end
        return neg[9:0];
    endfunction

    always_comb begin
        cnt_d   = cnt_q + 10'd1;
        mag_lft = mag_of(mc.lft);
        mag_rht = mag_of(mc.rht);
        pwm_lft = (cnt_q < mag_lft);
        pwm_rht = (cnt_q < mag_rht);

        fwd_lft_d = 1'b0;
        rev_lft_d = 1'b0;
        if (mc.lft == 11'd0) begin
            fwd_lft_d = 1'b1;
            rev_lft_d = 1'b1;
        end else if (mc.lft[10]) begin
            rev_lft_d = pwm_lft;
        end else begin
            fwd_lft_d = pwm_lft;
        end

        fwd_rht_d = 1'b0;
        rev_rht_d = 1'b0;
        if (mc.rht == 11'd0) begin
            fwd_rht_d = 1'b1;
            rev_rht_d = 1'b1;
        end else if (mc.rht[10]) begin
            rev_rht_d = pwm_rht;
        end else begin
            fwd_rht_d = pwm_rht;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 10'd0;
            fwd_lft_q <= 1'b0;
            rev_lft_q <= 1'b0;
            fwd_rht_q <= 1'b0;
            rev_rht_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            fwd_lft_q <= fwd_lft_d;
            rev_lft_q <= rev_lft_d;
            fwd_rht_q <= fwd_rht_d;
            rev_rht_q <= rev_rht_d;
        end
    end

    assign mc.fwd_lft = fwd_lft_q;
    assign mc.rev_lft = rev_lft_q;
    assign mc.fwd_rht = fwd_rht_q;
    assign mc.rev_rht = rev_rht_q;

endmodule

// File: tb/tb_motor_cntrl.sv
// Bench for motor_cntrl: directed duty-cycle periods plus random command and reset
// sequences, checked cycle by cycle against an arithmetic model of the PWM rules.
module tb_motor_cntrl;

    logic clk;
    logic rst_n;
    motor_cntrl_if mc ();

    motor_cntrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mc    (mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int mcnt;
    int hi_fl, hi_rl, hi_fr, hi_rr;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Magnitude of a signed 11-bit command, clamped to the 10-bit range.
    function automatic int mag_of(input logic [10:0] c);
        int v;
        v = int'($signed(c));
        if (v < 0) v = -v;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    // Returns {fwd, rev} for one side given the command and the counter phase.
    function automatic logic [1:0] drive_of(input logic [10:0] c, input int phase);
        logic pwm;
        if (c == 11'd0) return 2'b11;
        pwm = (phase < mag_of(c));
        if (int'($signed(c)) > 0) return {pwm, 1'b0};
        return {1'b0, pwm};
    endfunction

    task automatic clear_hi();
        hi_fl = 0; hi_rl = 0; hi_fr = 0; hi_rr = 0;
    endtask

    task automatic run_cycles(input int n);
        logic [1:0] el, er;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            el   = drive_of(mc.lft, mcnt);
            er   = drive_of(mc.rht, mcnt);
            mcnt = (mcnt + 1) % 1024;
            @(negedge clk);
            check_eq("drive", int'({mc.fwd_lft, mc.rev_lft, mc.fwd_rht, mc.rev_rht}),
                     int'({el, er}));
            hi_fl += int'(mc.fwd_lft);
            hi_rl += int'(mc.rev_lft);
            hi_fr += int'(mc.fwd_rht);
            hi_rr += int'(mc.rev_rht);
        end
    endtask

    task automatic period(input logic [10:0] l, input logic [10:0] r, input string tag,
                          input int efl, input int erl, input int efr, input int err);
        mc.lft = l;
        mc.rht = r;
        clear_hi();
        run_cycles(1024);
        check_eq({tag, " fwd_lft"}, hi_fl, efl);
        check_eq({tag, " rev_lft"}, hi_rl, erl);
        check_eq({tag, " fwd_rht"}, hi_fr, efr);
        check_eq({tag, " rev_rht"}, hi_rr, err);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, " async"}, int'({mc.fwd_lft, mc.rev_lft, mc.fwd_rht, mc.rev_rht}), 0);
        @(negedge clk);
        check_eq({tag, " held"}, int'({mc.fwd_lft, mc.rev_lft, mc.fwd_rht, mc.rev_rht}), 0);
        rst_n = 1'b1;
        mcnt  = 0;
    endtask

    function automatic logic [10:0] rand_cmd();
        case ($urandom_range(0, 7))
            0:       return 11'h000;
            1:       return 11'h400;
            2:       return 11'h001;
            3:       return 11'h7ff;
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mcnt    = 0;
        rst_n   = 1'b0;
        mc.lft  = 11'h000;
        mc.rht  = 11'h000;

        repeat (3) @(negedge clk);
        check_eq("reset outputs", int'({mc.fwd_lft, mc.rev_lft, mc.fwd_rht, mc.rev_rht}), 0);
        rst_n = 1'b1;

        // Brake for two periods.
        clear_hi();
        run_cycles(2048);
        check_eq("brake fwd_lft", hi_fl, 2048);
        check_eq("brake rev_lft", hi_rl, 2048);
        check_eq("brake fwd_rht", hi_fr, 2048);
        check_eq("brake rev_rht", hi_rr, 2048);

        period(11'h200, 11'h200, "half fwd", 512, 0, 512, 0);
        period(11'h600, 11'h600, "half rev", 0, 512, 0, 512);
        period(11'h001, 11'h3ff, "fwd ext", 1, 0, 1023, 0);
        period(11'h3ff, 11'h001, "fwd ext swap", 1023, 0, 1, 0);
        period(11'h401, 11'h7ff, "rev ext", 0, 1023, 0, 1);
        period(11'h7ff, 11'h401, "rev ext swap", 0, 1, 0, 1023);
        period(11'h400, 11'h400, "overflow", 0, 1023, 0, 1023);

        // Back to brake straight out of reverse: one registered clk later.
        mc.lft = 11'h000;
        mc.rht = 11'h000;
        run_cycles(1);
        check_eq("brake after rev", int'({mc.fwd_lft, mc.rev_lft, mc.fwd_rht, mc.rev_rht}), 15);

        mc.lft = 11'h200;
        mc.rht = 11'h600;
        run_cycles(300);
        pulse_reset("mid reset");
        run_cycles(20);

        // Random command changes of varying length, with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            mc.lft = rand_cmd();
            mc.rht = rand_cmd();
            run_cycles($urandom_range(1, 40));
            if ($urandom_range(0, 49) == 0) pulse_reset("rand reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
